// File: rtl/core_pkg.sv
// Shared pipeline-control types and constants for the RV32I core.
package core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WAIT_W     = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_e;

    // One bundle for every pipeline-register enable and flush.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_en;
    } pipe_ctrl_t;

    // Whole pipe frozen: nothing advances, nothing is cleared.
    localparam pipe_ctrl_t CTRL_HOLD     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Normal advance.
    localparam pipe_ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    // Taken branch/jump: advance and kill the two younger instructions.
    localparam pipe_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    // Load-use: hold PC and IF/ID, push a bubble into EX.
    localparam pipe_ctrl_t CTRL_BUBBLE   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus between the datapath (master) and pipe_hazard_ctrl (slave).
interface pipe_hazard_ctrl_if
    import core_pkg::*;
#(
    parameter int CNT_W = 32
);
    // Hazard sources reported by the datapath
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_is_load;
    logic                  ex_redirect;
    logic                  mem_req;
    logic                  mem_ready;

    // Pipeline-register controls and status back to the datapath
    logic                  pc_en;
    logic                  if_id_en;
    logic                  if_id_flush;
    logic                  id_ex_en;
    logic                  id_ex_flush;
    logic                  ex_mem_en;
    logic                  mem_wb_en;
    logic                  halted;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_redirect, mem_req, mem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_en, halted, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_redirect, mem_req, mem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_en, halted, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_ld_use_det.sv
// Load-use hazard detector: the ID instruction needs a register the EX load has not produced yet.
module hz_ld_use_det
    import core_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    output logic                  ld_use
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign ld_use  = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline, with data-memory timeout halt.
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
)(
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave hz
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    pipe_ctrl_t        ctrl;
    logic              mem_stall;
    logic              ld_use;

    assign mem_stall = hz.mem_req && !hz.mem_ready;

    hz_ld_use_det u_ld_use (
        .id_rs1     (hz.id_rs1),
        .id_rs2     (hz.id_rs2),
        .id_use_rs1 (hz.id_use_rs1),
        .id_use_rs2 (hz.id_use_rs2),
        .ex_rd      (hz.ex_rd),
        .ex_is_load (hz.ex_is_load),
        .ld_use     (ld_use)
    );

    // State, wait counter and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (!ctrl.pc_en && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // Next state: count consecutive memory wait cycles, halt when the budget runs out.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d    = state_q;
        wait_cnt_d = '0;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                // A dropped mem_req is treated like completion.
                if (!mem_stall) begin
                    state_d = RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs: prioritised pipe control, combinational from state and current inputs.
    always_comb begin
        ctrl = CTRL_HOLD;
        if (rst || (state_q == HALT))
            ctrl = CTRL_HOLD;
        else if (mem_stall)
            ctrl = CTRL_HOLD;     // freeze everything, EX redirect is preserved
        else if (hz.ex_redirect)
            ctrl = CTRL_REDIRECT; // ID instruction is flushed, so ld_use is moot
        else if (ld_use)
            ctrl = CTRL_BUBBLE;
        else
            ctrl = CTRL_RUN;
    end

    assign hz.pc_en       = ctrl.pc_en;
    assign hz.if_id_en    = ctrl.if_id_en;
    assign hz.if_id_flush = ctrl.if_id_flush;
    assign hz.id_ex_en    = ctrl.id_ex_en;
    assign hz.id_ex_flush = ctrl.id_ex_flush;
    assign hz.ex_mem_en   = ctrl.ex_mem_en;
    assign hz.mem_wb_en   = ctrl.mem_wb_en;
    assign hz.halted      = (state_q == HALT);
    assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_sat = 1'b1;
    int   tests = 0;
    int   failed = 0;

    // ctrl bit order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en
    localparam logic [6:0] C_HOLD   = 7'b0000000;
    localparam logic [6:0] C_RUN    = 7'b1101011;
    localparam logic [6:0] C_REDIR  = 7'b1111111;
    localparam logic [6:0] C_BUBBLE = 7'b0001111;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(32)) hz ();
    pipe_hazard_ctrl_if #(.CNT_W(3))  hz_sat ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    // Narrow counter instance used only to observe saturation.
    pipe_hazard_ctrl #(.MEM_TIMEOUT(2), .CNT_W(3)) dut_sat (
        .clk (clk),
        .rst (rst_sat),
        .hz  (hz_sat)
    );

    function automatic logic [6:0] ctrl_bits();
        return {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en,
                hz.id_ex_flush, hz.ex_mem_en, hz.mem_wb_en};
    endfunction

    task automatic idle();
        hz.id_rs1      = 5'd0;
        hz.id_rs2      = 5'd0;
        hz.id_use_rs1  = 1'b0;
        hz.id_use_rs2  = 1'b0;
        hz.ex_rd       = 5'd0;
        hz.ex_is_load  = 1'b0;
        hz.ex_redirect = 1'b0;
        hz.mem_req     = 1'b0;
        hz.mem_ready   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        #1;
        tests++;
        if (ctrl_bits() !== C_HOLD) begin
            failed++;
            $display("FAIL reset_ctrl: got %b want %b", ctrl_bits(), C_HOLD);
        end
        tests++;
        if (hz.halted !== 1'b0 || hz.stall_cnt !== 32'd0) begin
            failed++;
            $display("FAIL reset_status: halted=%b stall_cnt=%0d want 0/0", hz.halted, hz.stall_cnt);
        end
        step();
        rst = 1'b0;
        #1;
        tests++;
        if (ctrl_bits() !== C_RUN) begin
            failed++;
            $display("FAIL reset_release_ctrl: got %b want %b", ctrl_bits(), C_RUN);
        end
    endtask

    task automatic test_ld_use();
        do_reset();
        hz.ex_is_load = 1'b1;
        hz.ex_rd      = 5'd5;
        hz.id_rs1     = 5'd3;
        hz.id_use_rs1 = 1'b1;
        hz.id_rs2     = 5'd5;
        hz.id_use_rs2 = 1'b1;
        #1;
        tests++;
        if (ctrl_bits() !== C_BUBBLE) begin
            failed++;
            $display("FAIL ld_use_rs2_bubble: got %b want %b", ctrl_bits(), C_BUBBLE);
        end
        step();
        // Load moved to MEM, bubble now in EX.
        hz.ex_is_load = 1'b0;
        hz.ex_rd      = 5'd0;
        #1;
        tests++;
        if (ctrl_bits() !== C_RUN) begin
            failed++;
            $display("FAIL ld_use_after_bubble: got %b want %b", ctrl_bits(), C_RUN);
        end
        tests++;
        if (hz.stall_cnt !== 32'd1) begin
            failed++;
            $display("FAIL ld_use_stall_cnt: got %0d want 1", hz.stall_cnt);
        end
        step();
        // rs1 match, then same register but rs1 not used.
        hz.ex_is_load = 1'b1;
        hz.ex_rd      = 5'd7;
        hz.id_rs1     = 5'd7;
        hz.id_use_rs1 = 1'b1;
        hz.id_rs2     = 5'd9;
        hz.id_use_rs2 = 1'b1;
        #1;
        tests++;
        if (ctrl_bits() !== C_BUBBLE) begin
            failed++;
            $display("FAIL ld_use_rs1_bubble: got %b want %b", ctrl_bits(), C_BUBBLE);
        end
        hz.id_use_rs1 = 1'b0;
        #1;
        tests++;
        if (ctrl_bits() !== C_RUN) begin
            failed++;
            $display("FAIL ld_use_rs1_unused: got %b want %b", ctrl_bits(), C_RUN);
        end
        step();
        idle();
    endtask

    task automatic test_x0_load();
        do_reset();
        hz.ex_is_load = 1'b1;
        hz.ex_rd      = 5'd0;
        hz.id_rs1     = 5'd0;
        hz.id_use_rs1 = 1'b1;
        #1;
        tests++;
        if (ctrl_bits() !== C_RUN) begin
            failed++;
            $display("FAIL x0_no_stall: got %b want %b", ctrl_bits(), C_RUN);
        end
        step();
        tests++;
        if (hz.stall_cnt !== 32'd0) begin
            failed++;
            $display("FAIL x0_stall_cnt: got %0d want 0", hz.stall_cnt);
        end
        idle();
    endtask

    task automatic test_redirect_vs_ld_use();
        do_reset();
        hz.ex_is_load  = 1'b1;
        hz.ex_rd       = 5'd12;
        hz.id_rs1      = 5'd12;
        hz.id_use_rs1  = 1'b1;
        hz.ex_redirect = 1'b1;
        #1;
        tests++;
        if (ctrl_bits() !== C_REDIR) begin
            failed++;
            $display("FAIL redirect_over_ld_use: got %b want %b", ctrl_bits(), C_REDIR);
        end
        step();
        idle();
        #1;
        tests++;
        if (ctrl_bits() !== C_RUN || hz.stall_cnt !== 32'd0) begin
            failed++;
            $display("FAIL redirect_no_bubble: ctrl=%b stall_cnt=%0d want %b/0", ctrl_bits(), hz.stall_cnt, C_RUN);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        // Zero-wait access never stalls.
        hz.mem_req   = 1'b1;
        hz.mem_ready = 1'b1;
        #1;
        tests++;
        if (ctrl_bits() !== C_RUN) begin
            failed++;
            $display("FAIL zero_wait: got %b want %b", ctrl_bits(), C_RUN);
        end
        step();
        hz.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (ctrl_bits() !== C_HOLD || hz.halted !== 1'b0) begin
                failed++;
                $display("FAIL mem_wait_hold[%0d]: ctrl=%b halted=%b want %b/0", i, ctrl_bits(), hz.halted, C_HOLD);
            end
            step();
        end
        hz.mem_ready = 1'b1;
        #1;
        tests++;
        if (ctrl_bits() !== C_RUN) begin
            failed++;
            $display("FAIL mem_wait_done: got %b want %b", ctrl_bits(), C_RUN);
        end
        step();
        tests++;
        if (hz.stall_cnt !== 32'd3) begin
            failed++;
            $display("FAIL mem_wait_stall_cnt: got %0d want 3", hz.stall_cnt);
        end
        // Second 3-cycle wait must start from a cleared wait counter (no halt).
        hz.mem_ready = 1'b0;
        repeat (3) step();
        hz.mem_ready = 1'b1;
        #1;
        tests++;
        if (ctrl_bits() !== C_RUN || hz.halted !== 1'b0) begin
            failed++;
            $display("FAIL mem_wait_restart: ctrl=%b halted=%b want %b/0", ctrl_bits(), hz.halted, C_RUN);
        end
        step();
        // mem_req dropping mid-wait is taken as completion.
        hz.mem_ready = 1'b0;
        step();
        hz.mem_req = 1'b0;
        #1;
        tests++;
        if (ctrl_bits() !== C_RUN) begin
            failed++;
            $display("FAIL mem_req_drop: got %b want %b", ctrl_bits(), C_RUN);
        end
        step();
        tests++;
        if (hz.stall_cnt !== 32'd7 || hz.halted !== 1'b0) begin
            failed++;
            $display("FAIL mem_req_drop_state: stall_cnt=%0d halted=%b want 7/0", hz.stall_cnt, hz.halted);
        end
        idle();
    endtask

    task automatic test_timeout();
        do_reset();
        hz.mem_req   = 1'b1;
        hz.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (ctrl_bits() !== C_HOLD || hz.halted !== 1'b0) begin
                failed++;
                $display("FAIL timeout_wait[%0d]: ctrl=%b halted=%b want %b/0", i, ctrl_bits(), hz.halted, C_HOLD);
            end
            step();
        end
        tests++;
        if (hz.halted !== 1'b1) begin
            failed++;
            $display("FAIL timeout_halted: got %b want 1", hz.halted);
        end
        // HALT ignores inputs.
        hz.mem_ready   = 1'b1;
        hz.ex_redirect = 1'b1;
        #1;
        tests++;
        if (ctrl_bits() !== C_HOLD || hz.halted !== 1'b1) begin
            failed++;
            $display("FAIL halt_ignores_inputs: ctrl=%b halted=%b want %b/1", ctrl_bits(), hz.halted, C_HOLD);
        end
        step();
        tests++;
        if (hz.stall_cnt !== 32'd5) begin
            failed++;
            $display("FAIL halt_stall_cnt: got %0d want 5", hz.stall_cnt);
        end
        // Asynchronous reset mid-cycle.
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (hz.halted !== 1'b0 || hz.stall_cnt !== 32'd0 || ctrl_bits() !== C_HOLD) begin
            failed++;
            $display("FAIL halt_async_reset: halted=%b stall_cnt=%0d ctrl=%b want 0/0/%b",
                     hz.halted, hz.stall_cnt, ctrl_bits(), C_HOLD);
        end
        rst = 1'b0;
        idle();
        #1;
        tests++;
        if (ctrl_bits() !== C_RUN) begin
            failed++;
            $display("FAIL halt_reset_run: got %b want %b", ctrl_bits(), C_RUN);
        end
        step();
    endtask

    task automatic test_redirect_under_stall();
        do_reset();
        hz.mem_req     = 1'b1;
        hz.mem_ready   = 1'b0;
        hz.ex_redirect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if (ctrl_bits() !== C_HOLD) begin
                failed++;
                $display("FAIL redirect_held[%0d]: got %b want %b", i, ctrl_bits(), C_HOLD);
            end
            step();
        end
        hz.mem_ready = 1'b1;
        #1;
        tests++;
        if (ctrl_bits() !== C_REDIR) begin
            failed++;
            $display("FAIL redirect_on_ready: got %b want %b", ctrl_bits(), C_REDIR);
        end
        step();
        tests++;
        if (hz.stall_cnt !== 32'd2) begin
            failed++;
            $display("FAIL redirect_stall_cnt: got %0d want 2", hz.stall_cnt);
        end
        idle();
    endtask

    task automatic test_saturation();
        rst_sat = 1'b0;
        repeat (6) step();
        tests++;
        if (hz_sat.stall_cnt !== 3'd6 || hz_sat.halted !== 1'b1) begin
            failed++;
            $display("FAIL sat_progress: stall_cnt=%0d halted=%b want 6/1", hz_sat.stall_cnt, hz_sat.halted);
        end
        repeat (6) step();
        tests++;
        if (hz_sat.stall_cnt !== 3'd7) begin
            failed++;
            $display("FAIL sat_hold: got %0d want 7", hz_sat.stall_cnt);
        end
    endtask

    initial begin
        hz_sat.id_rs1      = 5'd0;
        hz_sat.id_rs2      = 5'd0;
        hz_sat.id_use_rs1  = 1'b0;
        hz_sat.id_use_rs2  = 1'b0;
        hz_sat.ex_rd       = 5'd0;
        hz_sat.ex_is_load  = 1'b0;
        hz_sat.ex_redirect = 1'b0;
        hz_sat.mem_req     = 1'b1;
        hz_sat.mem_ready   = 1'b0;

        test_reset();
        test_ld_use();
        test_x0_load();
        test_redirect_vs_ld_use();
        test_mem_wait();
        test_timeout();
        test_redirect_under_stall();
        test_saturation();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
